// File: rtl/riscv_alu_pkg.sv
// Shared ALU definitions: ALUControl codes (also used by the ALU decoder),
// FSM state encoding and default datapath widths.
package riscv_alu_pkg;

  localparam int XLEN    = 32;
  localparam int SHAMT_W = 5;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SLL = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_state_t;

endpackage

// File: rtl/alu_shift_step.sv
// Combinational single-step logical shifter: shifts value by 1 or 4 bits,
// zero-filling. dir=0 shifts left, dir=1 shifts right.
module alu_shift_step #(
  parameter int XLEN = 32
) (
  input  logic            dir,
  input  logic            by4,
  input  logic [XLEN-1:0] value,
  output logic [XLEN-1:0] shifted
);

  logic [XLEN-1:0] left1;
  logic [XLEN-1:0] left4;
  logic [XLEN-1:0] right1;
  logic [XLEN-1:0] right4;

  assign left1  = {value[XLEN-2:0], 1'b0};
  assign left4  = {value[XLEN-5:0], 4'b0000};
  assign right1 = {1'b0, value[XLEN-1:1]};
  assign right4 = {4'b0000, value[XLEN-1:4]};

  always_comb begin
    shifted = '0;
    case ({dir, by4})
      2'b00:   shifted = left1;
      2'b01:   shifted = left4;
      2'b10:   shifted = right1;
      default: shifted = right4;
    endcase
  end

endmodule

// File: rtl/iterative_alu.sv
// Multi-cycle execute-stage ALU: single-cycle add/sub/logic, iterative shifts.
// Define ALU_SHIFT4_EN to step shifts by 4 bits when at least 4 remain.
module iterative_alu #(
  parameter int XLEN    = riscv_alu_pkg::XLEN,
  parameter int SHAMT_W = riscv_alu_pkg::SHAMT_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      ALUControl,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] ALUResult,
  output logic            Zero
);

  import riscv_alu_pkg::*;

  alu_state_t          state_reg, state_next;
  logic [XLEN-1:0]     shreg_reg, shreg_next;
  logic [SHAMT_W-1:0]  cnt_reg, cnt_next;
  logic                dir_reg, dir_next;
  logic [XLEN-1:0]     result_reg, result_next;
  logic                zero_reg, zero_next;

  logic [SHAMT_W-1:0]  shamt;
  logic                is_shift;
  logic                by4;
  logic [SHAMT_W-1:0]  step;
  logic [XLEN-1:0]     step_out;
  logic [XLEN-1:0]     alu_out;

  assign shamt    = SrcB[SHAMT_W-1:0];
  assign is_shift = (ALUControl == ALU_SLL) || (ALUControl == ALU_SRL);

`ifdef ALU_SHIFT4_EN
  assign by4 = (cnt_reg >= SHAMT_W'(4));
`else
  assign by4 = 1'b0;
`endif
  assign step = by4 ? SHAMT_W'(4) : SHAMT_W'(1);

  alu_shift_step #(.XLEN(XLEN)) u_step (
    .dir     (dir_reg),
    .by4     (by4),
    .value   (shreg_reg),
    .shifted (step_out)
  );

  // Single-cycle datapath; code 011 and shift codes fall through to zero.
  always_comb begin
    alu_out = '0;
    case (ALUControl)
      ALU_ADD: alu_out = SrcA + SrcB;
      ALU_SUB: alu_out = SrcA + ~SrcB + XLEN'(1);
      ALU_XOR: alu_out = SrcA ^ SrcB;
      ALU_OR:  alu_out = SrcA | SrcB;
      ALU_AND: alu_out = SrcA & SrcB;
      default: alu_out = '0;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    shreg_next  = shreg_reg;
    cnt_next    = cnt_reg;
    dir_next    = dir_reg;
    result_next = result_reg;
    zero_next   = zero_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (is_shift) begin
            dir_next = (ALUControl == ALU_SRL);
            if (shamt == '0) begin
              result_next = SrcA;
              zero_next   = (SrcA == '0);
              state_next  = DONE;
            end else begin
              shreg_next = SrcA;
              cnt_next   = shamt;
              state_next = SHIFT;
            end
          end else begin
            result_next = alu_out;
            zero_next   = (alu_out == '0);
            state_next  = DONE;
          end
        end
      end
      SHIFT: begin
        shreg_next = step_out;
        cnt_next   = cnt_reg - step;
        // Last step: publish the shifted value straight from the stepper.
        if (cnt_reg == step) begin
          result_next = step_out;
          zero_next   = (step_out == '0);
          state_next  = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      shreg_reg  <= '0;
      cnt_reg    <= '0;
      dir_reg    <= 1'b0;
      result_reg <= '0;
      zero_reg   <= 1'b1;
    end else begin
      state_reg  <= state_next;
      shreg_reg  <= shreg_next;
      cnt_reg    <= cnt_next;
      dir_reg    <= dir_next;
      result_reg <= result_next;
      zero_reg   <= zero_next;
    end
  end

  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);
  assign ALUResult = result_reg;
  assign Zero      = zero_reg;

endmodule

// File: tb/tb_iterative_alu.sv
// Self-checking bench for iterative_alu: table-driven ops plus hand-written
// sequences for dropped starts, mid-shift reset and back-to-back issue.
module tb_iterative_alu;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  ALUControl;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        busy;
  logic        done;
  logic [31:0] ALUResult;
  logic        Zero;

  int total = 0;
  int bad   = 0;

`ifdef ALU_SHIFT4_EN
  localparam bit SHIFT4 = 1'b1;
`else
  localparam bit SHIFT4 = 1'b0;
`endif

  iterative_alu dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .ALUControl (ALUControl),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .busy       (busy),
    .done       (done),
    .ALUResult  (ALUResult),
    .Zero       (Zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          k;     // shift amount, -1 for single-cycle ops
  } vec_t;

  vec_t tbl[13];

  // Cycles from accept edge to the cycle where done is high.
  function automatic int exp_latency(input int k);
    if (k <= 0) return 1;
    if (SHIFT4) return (k / 4) + (k % 4) + 1;
    return k + 1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic run_op(input string nm, input logic [2:0] ctl, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    bit got;
    @(negedge clk);
    ALUControl = ctl; SrcA = a; SrcB = b; start = 1'b1;
    @(posedge clk);
    lat = 0; got = 1'b0;
    while (!got && lat < 200) begin
      @(negedge clk);
      if (lat == 0) begin
        start = 1'b0;
        SrcA  = ~a;          // inputs need not be held after accept
        SrcB  = b ^ 32'h5;
      end
      lat++;
      if (done) got = 1'b1;
    end
    chk({nm, "_done_seen"}, 32'(got), 32'd1);
    chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, "_result"}, ALUResult, exp);
    chk({nm, "_zero"}, 32'(Zero), 32'(exp == 32'd0));
    @(negedge clk);
    chk({nm, "_done_pulse_end"}, {30'd0, busy, done}, 32'd0);
    $display("op %s ctl=%b a=%h b=%h result=%h lat=%0d", nm, ctl, a, b, ALUResult, lat);
  endtask

  initial begin
    int dcount;
    int lat;

    tbl[0]  = '{"add",      3'b000, 32'd5,        32'd7,        32'd12,       -1};
    tbl[1]  = '{"sub_eq",   3'b010, 32'h10,       32'h10,       32'd0,        -1};
    tbl[2]  = '{"sub_neg",  3'b010, 32'd0,        32'd1,        32'hFFFFFFFF, -1};
    tbl[3]  = '{"add_wrap", 3'b000, 32'hFFFFFFFF, 32'd1,        32'd0,        -1};
    tbl[4]  = '{"xor",      3'b100, 32'hF0F0,     32'hFF00,     32'h0FF0,     -1};
    tbl[5]  = '{"or",       3'b110, 32'hF0F0,     32'hFF00,     32'hFFF0,     -1};
    tbl[6]  = '{"and",      3'b111, 32'hF0F0,     32'hFF00,     32'hF000,     -1};
    tbl[7]  = '{"unused",   3'b011, 32'd5,        32'd7,        32'd0,        -1};
    tbl[8]  = '{"sll31",    3'b001, 32'd1,        32'd31,       32'h80000000, 31};
    tbl[9]  = '{"srl3",     3'b101, 32'h80000000, 32'h23,       32'h10000000, 3};
    tbl[10] = '{"srl0",     3'b101, 32'h80000000, 32'h20,       32'h80000000, 0};
    tbl[11] = '{"sll4",     3'b001, 32'hDEADBEEF, 32'd4,        32'hEADBEEF0, 4};
    tbl[12] = '{"srl13",    3'b101, 32'hDEADBEEF, 32'd13,       32'h0006F56D, 13};

    rst_n = 1'b0; start = 1'b0; ALUControl = 3'b000; SrcA = '0; SrcB = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", ALUResult, 32'd0);
    chk("rst_zero", 32'(Zero), 32'd1);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++)
      run_op(tbl[i].name, tbl[i].ctl, tbl[i].a, tbl[i].b, tbl[i].res, exp_latency(tbl[i].k));

    // start held high (as ADD) through SHIFT and DONE of an SLL 3<<3: dropped.
    @(negedge clk);
    ALUControl = 3'b001; SrcA = 32'd3; SrcB = 32'd3; start = 1'b1;
    @(posedge clk);
    dcount = 0; lat = 0;
    while (dcount == 0 && lat < 100) begin
      @(negedge clk);
      ALUControl = 3'b000; SrcA = 32'd1; SrcB = 32'd1;
      lat++;
      if (done) dcount++;
    end
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("drop_latency", 32'(lat), 32'(exp_latency(3)));
    chk("drop_done_count", 32'(dcount), 32'd1);
    chk("drop_result", ALUResult, 32'd24);
    chk("drop_idle", 32'(busy), 32'd0);
    $display("op drop_start result=%h dones=%0d", ALUResult, dcount);

    // Reset asserted 5 cycles into SLL 1<<20: immediate IDLE, no done.
    @(negedge clk);
    ALUControl = 3'b001; SrcA = 32'd1; SrcB = 32'd20; start = 1'b1;
    @(posedge clk);
    dcount = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) dcount++;
    end
    chk("midrst_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_result", ALUResult, 32'd0);
    chk("midrst_zero", 32'(Zero), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    chk("midrst_no_done", 32'(dcount), 32'd0);
    $display("op midshift_reset dones=%0d", dcount);
    run_op("add_after_rst", 3'b000, 32'd2, 32'd2, 32'd4, 1);

    // start held continuously: one ADD every 2 cycles.
    @(negedge clk);
    ALUControl = 3'b000; SrcA = 32'd1; SrcB = 32'd2; start = 1'b1;
    dcount = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done) dcount++;
    end
    start = 1'b0;
    chk("b2b_done_count", 32'(dcount), 32'd4);
    chk("b2b_result", ALUResult, 32'd3);
    $display("op back_to_back dones=%0d result=%h", dcount, ALUResult);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
